// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave frame controller: state encoding,
// R/W bit meaning and the bit-counter width rule.
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      ADDR       = 3'd1,
      WRITE      = 3'd2,
      READ_LOAD  = 3'd3,
      READ_SHIFT = 3'd4,
      NEXT       = 3'd5
   } state_e;

   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ  = 1'b1;

   // Wide enough to hold ADDR_W (the R/W sample point) and DATA_W.
   function automatic int cnt_width(input int addr_w, input int data_w);
      int m;
      m = (addr_w + 1 > data_w) ? addr_w + 1 : data_w;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// Bit counter for the SPI frame: synchronous clear has priority over
// increment; tc flags when the count equals the supplied terminal value.
module spi_bit_counter #(
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr_i,
   input  logic          inc_i,
   input  logic [CW-1:0] tc_val_i,
   output logic [CW-1:0] cnt_o,
   output logic          tc_o
);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (inc_i) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign cnt_o = cnt_q;
   assign tc_o  = (cnt_q == tc_val_i);

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave frame sequencer: address phase, then write or read words,
// optionally bursting at auto-incremented addresses while cs_n stays low.
//
// state      | meaning
// IDLE       | waiting for cs_n low
// ADDR       | shifting address bits, then sampling the R/W bit
// WRITE      | shifting one write word; last bit strobes dm_we
// READ_LOAD  | one clk; the following clk carries sr_we
// READ_SHIFT | MISO driven while one read word shifts out
// NEXT       | word boundary; burst advances address, else wait for cs_n
module spi_slave_ctrl
   import spi_pkg::*;
#(
   parameter int ADDR_W   = 7,
   parameter int DATA_W   = 8,
   parameter int BURST_EN = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sclk_pos,
   input  logic cs_n,
   input  logic shift_reg_out,
   output logic addr_we,
   output logic dm_we,
   output logic sr_we,
   output logic miso_buff,
   output logic addr_inc,
   output logic busy,
   output logic frame_err
);

   localparam int CW = cnt_width(ADDR_W, DATA_W);

   state_e        state_q, state_d;
   logic          dir_q, dir_d;
   logic          addr_we_q, addr_we_d, dm_we_q, dm_we_d, sr_we_q, sr_we_d;
   logic          miso_q, miso_d, inc_q, inc_d, busy_q, busy_d, err_q, err_d;
   logic [CW-1:0] cnt, tc_val;
   logic          tc, cnt_clr, cnt_inc;

   assign tc_val  = (state_q == ADDR) ? CW'(ADDR_W) : CW'(DATA_W - 1);
   assign cnt_clr = (state_d != state_q) || (state_q == IDLE);
   assign cnt_inc = sclk_pos && !cs_n && !cnt_clr &&
                    (state_q == ADDR || state_q == WRITE || state_q == READ_SHIFT);

   spi_bit_counter #(.CW(CW)) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (cnt_clr),
      .inc_i    (cnt_inc),
      .tc_val_i (tc_val),
      .cnt_o    (cnt),
      .tc_o     (tc)
   );

   always_comb begin
      state_d   = state_q;
      dir_d     = dir_q;
      addr_we_d = 1'b0;
      dm_we_d   = 1'b0;
      sr_we_d   = 1'b0;
      inc_d     = 1'b0;
      err_d     = 1'b0;
      case (state_q)
         IDLE: if (!cs_n) state_d = ADDR;
         ADDR: begin
            if (cs_n) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end else if (sclk_pos && tc) begin
               addr_we_d = 1'b1;
               dir_d     = shift_reg_out;
               state_d   = (shift_reg_out == RW_READ) ? READ_LOAD : WRITE;
            end
         end
         WRITE: begin
            if (cs_n) begin
               state_d = IDLE;
               err_d   = (cnt != '0);
            end else if (sclk_pos && tc) begin
               dm_we_d = 1'b1;
               state_d = NEXT;
            end
         end
         READ_LOAD: begin
            if (cs_n) begin
               state_d = IDLE;
            end else begin
               sr_we_d = 1'b1;
               state_d = READ_SHIFT;
            end
         end
         READ_SHIFT: begin
            if (cs_n) begin
               state_d = IDLE;
               err_d   = (cnt != '0);
            end else if (sclk_pos && tc) begin
               state_d = NEXT;
            end
         end
         NEXT: begin
            if (cs_n) begin
               state_d = IDLE;
            end else if (BURST_EN != 0) begin
               inc_d   = 1'b1;
               state_d = (dir_q == RW_READ) ? READ_LOAD : WRITE;
            end
         end
         default: state_d = IDLE;
      endcase
      miso_d = (state_d == READ_SHIFT);
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         dir_q     <= RW_WRITE;
         addr_we_q <= 1'b0;
         dm_we_q   <= 1'b0;
         sr_we_q   <= 1'b0;
         miso_q    <= 1'b0;
         inc_q     <= 1'b0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         dir_q     <= dir_d;
         addr_we_q <= addr_we_d;
         dm_we_q   <= dm_we_d;
         sr_we_q   <= sr_we_d;
         miso_q    <= miso_d;
         inc_q     <= inc_d;
         busy_q    <= busy_d;
         err_q     <= err_d;
      end
   end

   assign addr_we   = addr_we_q;
   assign dm_we     = dm_we_q;
   assign sr_we     = sr_we_q;
   assign miso_buff = miso_q;
   assign addr_inc  = inc_q;
   assign busy      = busy_q;
   assign frame_err = err_q;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Self-checking bench for spi_slave_ctrl: default instance (7/8/burst) and a
// 10/16/no-burst instance, driven by a frame table plus reset corner cases.
module tb_spi_slave_ctrl;

   logic clk = 1'b0;
   logic rst_n, sclk_pos, shift_reg_out, cs_n_a, cs_n_b;
   logic a_addr_we, a_dm_we, a_sr_we, a_miso, a_inc, a_busy, a_err;
   logic b_addr_we, b_dm_we, b_sr_we, b_miso, b_inc, b_busy, b_err;

   int n_checks = 0;
   int n_fail   = 0;
   int pulse_idx = 0;

   int a_addr_n = 0, a_addr_at = 0, a_dm_n = 0, a_dm_at = 0, a_sr_n = 0, a_inc_n = 0, a_err_n = 0, a_oh = 0;
   int b_addr_n = 0, b_addr_at = 0, b_dm_n = 0, b_dm_at = 0, b_sr_n = 0, b_inc_n = 0, b_err_n = 0, b_oh = 0;

   always #5 clk = ~clk;

   spi_slave_ctrl dut_a (
      .clk(clk), .rst_n(rst_n), .sclk_pos(sclk_pos), .cs_n(cs_n_a),
      .shift_reg_out(shift_reg_out), .addr_we(a_addr_we), .dm_we(a_dm_we),
      .sr_we(a_sr_we), .miso_buff(a_miso), .addr_inc(a_inc), .busy(a_busy),
      .frame_err(a_err)
   );

   spi_slave_ctrl #(.ADDR_W(10), .DATA_W(16), .BURST_EN(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .sclk_pos(sclk_pos), .cs_n(cs_n_b),
      .shift_reg_out(shift_reg_out), .addr_we(b_addr_we), .dm_we(b_dm_we),
      .sr_we(b_sr_we), .miso_buff(b_miso), .addr_inc(b_inc), .busy(b_busy),
      .frame_err(b_err)
   );

   // Strobe monitors; the pulse index tags which sclk_pos caused a strobe.
   always @(negedge clk) begin
      if (a_addr_we) begin a_addr_n <= a_addr_n + 1; a_addr_at <= pulse_idx; end
      if (a_dm_we)   begin a_dm_n <= a_dm_n + 1; a_dm_at <= pulse_idx; end
      if (a_sr_we)   a_sr_n  <= a_sr_n + 1;
      if (a_inc)     a_inc_n <= a_inc_n + 1;
      if (a_err)     a_err_n <= a_err_n + 1;
      if (int'(a_addr_we) + int'(a_dm_we) + int'(a_sr_we) + int'(a_inc) > 1) a_oh <= a_oh + 1;
   end

   always @(negedge clk) begin
      if (b_addr_we) begin b_addr_n <= b_addr_n + 1; b_addr_at <= pulse_idx; end
      if (b_dm_we)   begin b_dm_n <= b_dm_n + 1; b_dm_at <= pulse_idx; end
      if (b_sr_we)   b_sr_n  <= b_sr_n + 1;
      if (b_inc)     b_inc_n <= b_inc_n + 1;
      if (b_err)     b_err_n <= b_err_n + 1;
      if (int'(b_addr_we) + int'(b_dm_we) + int'(b_sr_we) + int'(b_inc) > 1) b_oh <= b_oh + 1;
   end

   typedef struct {
      int which; int np; bit rw; int aw;
      int e_addr; int e_addr_at; int e_dm; int e_dm_at;
      int e_sr; int e_inc; int e_err; bit e_miso; bit e_busy;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse(input bit b);
      sclk_pos      = 1'b1;
      shift_reg_out = b;
      pulse_idx++;
      tick(1);
      sclk_pos = 1'b0;
      tick(3);
   endtask

   function automatic int mon(input int w, input int k);
      case (k)
         0: return (w != 0) ? b_addr_n  : a_addr_n;
         1: return (w != 0) ? b_addr_at : a_addr_at;
         2: return (w != 0) ? b_dm_n    : a_dm_n;
         3: return (w != 0) ? b_dm_at   : a_dm_at;
         4: return (w != 0) ? b_sr_n    : a_sr_n;
         5: return (w != 0) ? b_inc_n   : a_inc_n;
         6: return (w != 0) ? b_err_n   : a_err_n;
         default: return 0;
      endcase
   endfunction

   task automatic set_cs(input int w, input logic v);
      if (w != 0) cs_n_b = v;
      else        cs_n_a = v;
   endtask

   task automatic apply(input vec_t v, input int r);
      int s[7];
      for (int k = 0; k < 7; k++) s[k] = mon(v.which, k);
      pulse_idx = 0;
      set_cs(v.which, 1'b0);
      tick(2);
      for (int i = 0; i < v.np; i++) pulse((i == v.aw) ? v.rw : 1'($urandom_range(0, 1)));
      check($sformatf("row%0d busy_before", r), int'((v.which != 0) ? b_busy : a_busy), int'(v.e_busy));
      check($sformatf("row%0d miso_before", r), int'((v.which != 0) ? b_miso : a_miso), int'(v.e_miso));
      set_cs(v.which, 1'b1);
      tick(1);
      check($sformatf("row%0d miso_after", r), int'((v.which != 0) ? b_miso : a_miso), 0);
      check($sformatf("row%0d busy_after", r), int'((v.which != 0) ? b_busy : a_busy), 0);
      tick(2);
      check($sformatf("row%0d addr_we_cnt", r), mon(v.which, 0) - s[0], v.e_addr);
      if (v.e_addr > 0) check($sformatf("row%0d addr_we_at", r), mon(v.which, 1), v.e_addr_at);
      check($sformatf("row%0d dm_we_cnt", r), mon(v.which, 2) - s[2], v.e_dm);
      if (v.e_dm > 0) check($sformatf("row%0d dm_we_at", r), mon(v.which, 3), v.e_dm_at);
      check($sformatf("row%0d sr_we_cnt", r), mon(v.which, 4) - s[4], v.e_sr);
      check($sformatf("row%0d addr_inc_cnt", r), mon(v.which, 5) - s[5], v.e_inc);
      check($sformatf("row%0d frame_err_cnt", r), mon(v.which, 6) - s[6], v.e_err);
   endtask

   initial begin
      int s_err, s_dm;
      //          which np rw aw  addr at  dm at  sr inc err miso busy
      vecs[0] = '{0, 16, 1'b0, 7,  1, 8,  1, 16, 0, 1, 0, 1'b0, 1'b1};
      vecs[1] = '{0, 16, 1'b1, 7,  1, 8,  0, 0,  2, 1, 0, 1'b1, 1'b1};
      vecs[2] = '{0, 4,  1'b0, 7,  0, 0,  0, 0,  0, 0, 1, 1'b0, 1'b1};
      vecs[3] = '{0, 32, 1'b0, 7,  1, 8,  3, 32, 0, 3, 0, 1'b0, 1'b1};
      vecs[4] = '{0, 11, 1'b0, 7,  1, 8,  0, 0,  0, 0, 1, 1'b0, 1'b1};
      vecs[5] = '{0, 12, 1'b1, 7,  1, 8,  0, 0,  1, 0, 1, 1'b1, 1'b1};
      vecs[6] = '{0, 8,  1'b0, 7,  1, 8,  0, 0,  0, 0, 0, 1'b0, 1'b1};
      vecs[7] = '{0, 0,  1'b0, 7,  0, 0,  0, 0,  0, 0, 1, 1'b0, 1'b1};
      vecs[8] = '{1, 32, 1'b0, 10, 1, 11, 1, 27, 0, 0, 0, 1'b0, 1'b1};

      rst_n = 1'b0; sclk_pos = 1'b0; shift_reg_out = 1'b0;
      cs_n_a = 1'b1; cs_n_b = 1'b1;
      #2;
      check("rst addr_we", int'(a_addr_we), 0);
      check("rst dm_we", int'(a_dm_we), 0);
      check("rst sr_we", int'(a_sr_we), 0);
      check("rst miso_buff", int'(a_miso), 0);
      check("rst addr_inc", int'(a_inc), 0);
      check("rst busy", int'(a_busy), 0);
      check("rst frame_err", int'(a_err), 0);
      check("rst busy_b", int'(b_busy), 0);
      tick(2);
      rst_n = 1'b1;
      tick(2);

      for (int r = 0; r < 9; r++) apply(vecs[r], r);

      // Reset asserted between edges while a read word is shifting out.
      pulse_idx = 0;
      cs_n_a = 1'b0;
      tick(2);
      for (int i = 0; i < 10; i++) pulse(i == 7);
      check("midrst miso_before", int'(a_miso), 1);
      check("midrst busy_before", int'(a_busy), 1);
      s_err = a_err_n;
      s_dm  = a_dm_n;
      #3 rst_n = 1'b0;
      #1;
      check("midrst miso_now", int'(a_miso), 0);
      check("midrst busy_now", int'(a_busy), 0);
      check("midrst err_now", int'(a_err), 0);
      cs_n_a = 1'b1;
      #1 rst_n = 1'b1;
      tick(2);
      check("midrst no_frame_err", a_err_n - s_err, 0);
      check("midrst no_dm_we", a_dm_n - s_dm, 0);
      apply(vecs[0], 9);

      check("onehot_a", a_oh, 0);
      check("onehot_b", b_oh, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
